// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency single-port memory between instruction
//            fetch and load/store, data-first with a fetch-starvation limiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
   parameter int AW          = 32,
   parameter int MEM_LAT     = 1,
   parameter int MAX_DSTREAK = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [31:0]   if_rdata_o,
   input  logic          d_req_i,
   input  logic          d_we_i,
   input  logic [3:0]    d_be_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [31:0]   d_wdata_i,
   output logic          d_gnt_o,
   output logic          d_rvalid_o,
   output logic [31:0]   d_rdata_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [3:0]    mem_be_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int SW = $clog2(MAX_DSTREAK + 1);
   localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT - 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] lat_q, lat_d;
   logic [SW-1:0] dstreak_q, dstreak_d;
   logic          own_data_q, own_data_d;
   logic          we_q, we_d;

   logic w_done, w_slot, w_fetch_win, w_data_win, w_if_gnt, w_d_gnt, w_d_store;

   // The completion cycle doubles as the next issue slot, so no bubble appears.
   assign w_done      = (state_q == WAIT) && (lat_q == '0);
   assign w_slot      = (state_q == IDLE) || w_done;
   assign w_fetch_win = if_req_i && (!d_req_i || (dstreak_q == STREAK_MAX));
   assign w_data_win  = d_req_i && !w_fetch_win;
   assign w_if_gnt    = rst_ni && w_slot && w_fetch_win;
   assign w_d_gnt     = rst_ni && w_slot && w_data_win;
   assign w_d_store   = w_d_gnt && d_we_i;

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      own_data_d = own_data_q;
      we_d       = we_q;
      dstreak_d  = dstreak_q;

      if (w_slot) begin
         if (if_req_i || d_req_i) begin
            state_d    = WAIT;
            lat_d      = LAT_LOAD;
            own_data_d = w_data_win;
            we_d       = w_data_win && d_we_i;
         end else begin
            state_d = IDLE;
         end
      end else begin
         lat_d = lat_q - CW'(1);
      end

      if (!if_req_i || (w_slot && w_fetch_win)) begin
         dstreak_d = '0;
      end else if (w_slot && w_data_win && (dstreak_q != STREAK_MAX)) begin
         dstreak_d = dstreak_q + SW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         lat_q      <= '0;
         dstreak_q  <= '0;
         own_data_q <= 1'b0;
         we_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         dstreak_q  <= dstreak_d;
         own_data_q <= own_data_d;
         we_q       <= we_d;
      end
   end

   assign if_gnt_o    = w_if_gnt;
   assign d_gnt_o     = w_d_gnt;
   assign mem_en_o    = w_if_gnt || w_d_gnt;
   assign mem_we_o    = w_d_store;
   assign mem_be_o    = w_d_store ? d_be_i : ((w_if_gnt || w_d_gnt) ? 4'hF : 4'h0);
   assign mem_addr_o  = w_d_gnt ? d_addr_i : (w_if_gnt ? if_addr_i : '0);
   assign mem_wdata_o = w_d_store ? d_wdata_i : 32'h0;

   // Reset gating keeps an abandoned access from surfacing while rst_ni is low.
   assign if_rvalid_o = rst_ni && w_done && !own_data_q;
   assign d_rvalid_o  = rst_ni && w_done && own_data_q;
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
   assign d_rdata_o   = (d_rvalid_o && !we_q) ? mem_rdata_i : 32'h0;

endmodule

`default_nettype wire
